// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - RISC-V instruction fetch stage with IF/ID register
//
// Purpose:
//   Holds the program counter and drives the word address into inst_mem.
//   Captures the returned word into the IF/ID register and hands it to
//   decode with a valid/ready handshake. Handles stalls, branch/jump
//   redirects and fetches beyond the end of inst_mem.
//
// Ports:
//   clk_i             in   1   core clock, rising edge
//   rst_i             in   1   asynchronous active-high reset
//   redirect_valid_i  in   1   branch/jump taken, load redirect_pc_i
//   redirect_pc_i     in   32  byte target address
//   imem_addr_o       out  32  word index into inst_mem (pc >> 2)
//   imem_inst_i       in   32  combinational read data from inst_mem
//   if_valid_o        out  1   IF/ID holds a valid instruction
//   if_ready_i        in   1   decode accepts IF/ID this cycle
//   if_pc_o           out  32  byte PC of the IF/ID instruction
//   if_inst_o         out  32  IF/ID instruction
//   misalign_trap_o   out  1   sticky misaligned-redirect flag
//                              (only with FETCH_MISALIGN_TRAP_EN)
//
// Configuration macro: FETCH_MISALIGN_TRAP_EN

module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 10,
  parameter logic [31:0] NOP_INST   = 32'h0000_0033
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_inst_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap_o
`endif
);

  localparam logic [0:0] S_BOOT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic [31:0] word_idx;
  logic        in_range;
  logic [31:0] fetch_word;
  logic        load;
  logic [31:0] redirect_target;

  assign word_idx        = {2'b00, pc_q[31:2]};
  assign in_range        = word_idx < 32'(IMEM_DEPTH);
  // Fetches past the end of inst_mem still produce a valid slot, just a NOP.
  assign fetch_word      = in_range ? imem_inst_i : NOP_INST;
  assign load            = !if_valid_q || if_ready_i;
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d     = trap_q;
`endif
    case (state_q)
      // Idle cycle after reset so inst_mem can finish loading; redirects ignored.
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (redirect_valid_i) begin
          // Redirect beats a stall: the wrong-path slot is dropped either way.
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          trap_d     = |redirect_pc_i[1:0];
`endif
        end else if (load) begin
          if_pc_d    = pc_q;
          if_inst_d  = fetch_word;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0000_0000;
      if_inst_q  <= NOP_INST;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q     <= trap_d;
`endif
    end
  end

  assign imem_addr_o = word_idx;
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_inst_o   = if_inst_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_trap_o = trap_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch

module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  logic [31:0] imem [10];
  logic [63:0] sb_q [$];
  logic [63:0] exp;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Out-of-range reads return junk so NOP substitution is visible.
  always_comb begin
    imem_inst = 32'hDEAD_BEEF;
    if (imem_addr < 32'd10) imem_inst = imem[imem_addr[3:0]];
  end

  inst_fetch dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_addr_o      (imem_addr),
    .imem_inst_i      (imem_inst),
    .if_valid_o       (if_valid),
    .if_ready_i       (if_ready),
    .if_pc_o          (if_pc),
    .if_inst_o        (if_inst)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_trap_o  (misalign_trap)
`endif
  );

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    logic [31:0] w;
    w = pc >> 2;
    return (w < 32'd10) ? imem[w[3:0]] : NOP;
  endfunction

  task automatic push(input logic [31:0] pc);
    sb_q.push_back({pc, exp_inst(pc)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    step(); step();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc); end
    checks++; if (if_inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", if_inst, NOP); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    step();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b want 0", if_valid); end
    push(32'h0); push(32'h4);
    for (int c = 0; c < 10 && sb_q.size() > 0; c++) begin
      if (if_valid && if_ready) begin
        exp = sb_q.pop_front();
        checks++;
        if (if_pc !== exp[63:32] || if_inst !== exp[31:0]) begin
          errors++; $display("FAIL seq_fetch: got pc=%h inst=%h want pc=%h inst=%h", if_pc, if_inst, exp[63:32], exp[31:0]);
        end
      end
      step();
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL seq_timeout: %0d left want 0", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_stall();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8) begin errors++; $display("FAIL stall_entry: got v=%b pc=%h want v=1 pc=8", if_valid, if_pc); end
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== imem[2] || imem_addr !== 32'd3) begin
        errors++; $display("FAIL stall_hold: got v=%b pc=%h inst=%h addr=%h want v=1 pc=8 inst=%h addr=3", if_valid, if_pc, if_inst, imem_addr, imem[2]);
      end
    end
    if_ready = 1'b1;
    push(32'h8); push(32'hC);
    for (int c = 0; c < 10 && sb_q.size() > 0; c++) begin
      if (if_valid && if_ready) begin
        exp = sb_q.pop_front();
        checks++;
        if (if_pc !== exp[63:32] || if_inst !== exp[31:0]) begin
          errors++; $display("FAIL stall_resume: got pc=%h inst=%h want pc=%h inst=%h", if_pc, if_inst, exp[63:32], exp[31:0]);
        end
      end
      step();
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL stall_timeout: %0d left want 0", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_redirect_stall();
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h4;
    step();
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'd1) begin errors++; $display("FAIL redir_flush: got v=%b addr=%h want v=0 addr=1", if_valid, imem_addr); end
    if_ready = 1'b1;
    push(32'h4);
    for (int c = 0; c < 5 && sb_q.size() > 0; c++) begin
      if (if_valid && if_ready) begin
        exp = sb_q.pop_front();
        checks++;
        if (if_pc !== exp[63:32] || if_inst !== exp[31:0]) begin
          errors++; $display("FAIL redir_target: got pc=%h inst=%h want pc=%h inst=%h", if_pc, if_inst, exp[63:32], exp[31:0]);
        end
      end
      step();
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL redir_timeout: %0d left want 0", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_out_of_range();
    for (int i = 2; i < 12; i++) push(32'(i * 4));
    for (int c = 0; c < 20 && sb_q.size() > 0; c++) begin
      if (if_valid && if_ready) begin
        exp = sb_q.pop_front();
        checks++;
        if (if_pc !== exp[63:32] || if_inst !== exp[31:0]) begin
          errors++; $display("FAIL oor_fetch: got pc=%h inst=%h want pc=%h inst=%h", if_pc, if_inst, exp[63:32], exp[31:0]);
        end
      end
      step();
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL oor_timeout: %0d left want 0", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_reset_mid();
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10) begin errors++; $display("FAIL mid_setup: got v=%b pc=%h want v=1 pc=10", if_valid, if_pc); end
    #2 rst = 1'b1;
    #1;
    checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL mid_async_reset: got v=%b pc=%h addr=%h want v=0 pc=0 addr=0", if_valid, if_pc, imem_addr);
    end
    step();
    rst = 1'b0;
    // Redirect during BOOT must be ignored.
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL boot_redirect: got v=%b addr=%h want v=0 addr=0", if_valid, imem_addr); end
    push(32'h0); push(32'h4);
    for (int c = 0; c < 10 && sb_q.size() > 0; c++) begin
      if (if_valid && if_ready) begin
        exp = sb_q.pop_front();
        checks++;
        if (if_pc !== exp[63:32] || if_inst !== exp[31:0]) begin
          errors++; $display("FAIL restart_fetch: got pc=%h inst=%h want pc=%h inst=%h", if_pc, if_inst, exp[63:32], exp[31:0]);
        end
      end
      step();
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL restart_timeout: %0d left want 0", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    push(32'hFFFF_FFFC); push(32'h0); push(32'h4);
    for (int c = 0; c < 10 && sb_q.size() > 0; c++) begin
      if (if_valid && if_ready) begin
        exp = sb_q.pop_front();
        checks++;
        if (if_pc !== exp[63:32] || if_inst !== exp[31:0]) begin
          errors++; $display("FAIL wrap_fetch: got pc=%h inst=%h want pc=%h inst=%h", if_pc, if_inst, exp[63:32], exp[31:0]);
        end
      end
      step();
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL wrap_timeout: %0d left want 0", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    step();
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'd1) begin errors++; $display("FAIL misalign_addr: got v=%b addr=%h want v=0 addr=1", if_valid, imem_addr); end
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (misalign_trap !== 1'b1) begin errors++; $display("FAIL trap_set: got %b want 1", misalign_trap); end
`endif
    push(32'h4); push(32'h8);
    for (int c = 0; c < 10 && sb_q.size() > 0; c++) begin
      if (if_valid && if_ready) begin
        exp = sb_q.pop_front();
        checks++;
        if (if_pc !== exp[63:32] || if_inst !== exp[31:0]) begin
          errors++; $display("FAIL misalign_fetch: got pc=%h inst=%h want pc=%h inst=%h", if_pc, if_inst, exp[63:32], exp[31:0]);
        end
      end
      step();
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL misalign_timeout: %0d left want 0", sb_q.size()); sb_q.delete(); end
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (misalign_trap !== 1'b1) begin errors++; $display("FAIL trap_sticky: got %b want 1", misalign_trap); end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL trap_clear: got %b want 0", misalign_trap); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 10; i++) imem[i] = 32'h1357_0000 + 32'(i * 32'h111);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_out_of_range();
    test_reset_mid();
    test_wrap();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
